// File: rtl/output_register.sv
// Captures one generator burst into a FWFT FIFO and streams it to the DAC over valid/ready.
// Latency: a sample pushed into an empty FIFO is on DAC_DATA after the push edge; producer is never stalled, so overflowing samples are dropped and flagged.
module output_register #(
    parameter int DATA_WIDTH = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  SIGN_START_CALC,
    input  logic                  SIGN_STOP_CALC,
    output logic                  OUT_REG_READY,
    output logic [DATA_WIDTH-1:0] DAC_DATA,
    output logic                  DAC_VALID,
    input  logic                  DAC_READY,
    output logic                  BUSY,
    output logic                  OVERFLOW,
    output logic [31:0]           SAMPLE_COUNT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic [31:0]             sample_count_q, sample_count_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];

    logic push_try;
    logic push_ok;
    logic pop;

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        overflow_d     = overflow_q;
        sample_count_d = sample_count_q;

        pop      = (count_q != '0) && DAC_READY;
        push_try = (state_q == ST_CAPTURE);
        // A full FIFO still accepts when the head leaves on the same edge.
        push_ok  = push_try && ((count_q != FULL_CNT) || pop);

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (sample_count_q != 32'hFFFF_FFFF) begin
                sample_count_d = sample_count_q + 32'd1;
            end
        end
        if (push_try && !push_ok) begin
            overflow_d = 1'b1;
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (SIGN_START_CALC) begin
                    state_d        = ST_CAPTURE;
                    sample_count_d = '0;
                    overflow_d     = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (SIGN_STOP_CALC) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            sample_count_q <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            sample_count_q <= sample_count_d;
        end
    end

    // Storage is not reset; an empty FIFO masks whatever it holds.
    always_ff @(posedge CLK) begin
        if (push_ok && !RESET) begin
            mem_q[wr_ptr_q] <= DATA_IN;
        end
    end

    assign OUT_REG_READY = (state_q == ST_IDLE);
    assign BUSY          = (state_q != ST_IDLE);
    assign DAC_VALID     = (count_q != '0);
    assign DAC_DATA      = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign OVERFLOW      = overflow_q;
    assign SAMPLE_COUNT  = sample_count_q;

endmodule

// File: tb/tb_output_register.sv
// Bench for output_register: queue-based model checked every cycle, plus literal expectations per scenario.
module tb_output_register;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [11:0] DATA_IN = '0;
    logic        SIGN_START_CALC = 1'b0;
    logic        SIGN_STOP_CALC = 1'b0;
    logic        OUT_REG_READY;
    logic [11:0] DAC_DATA;
    logic        DAC_VALID;
    logic        DAC_READY = 1'b0;
    logic        BUSY;
    logic        OVERFLOW;
    logic [31:0] SAMPLE_COUNT;

    output_register #(.DATA_WIDTH(12), .FIFO_DEPTH(16), .ADDR_WIDTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN),
        .SIGN_START_CALC(SIGN_START_CALC), .SIGN_STOP_CALC(SIGN_STOP_CALC),
        .OUT_REG_READY(OUT_REG_READY), .DAC_DATA(DAC_DATA), .DAC_VALID(DAC_VALID),
        .DAC_READY(DAC_READY), .BUSY(BUSY), .OVERFLOW(OVERFLOW), .SAMPLE_COUNT(SAMPLE_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the FIFO is a queue; a burst is "capturing" until STOP, then "draining" until empty.
    logic [11:0] mq[$];
    logic [11:0] popped[$];
    bit          m_capturing = 0;
    bit          m_draining  = 0;
    bit          m_ovf = 0;
    longint      m_cnt = 0;
    bit          model_live = 0;

    always @(posedge CLK) begin
        if (RESET) begin
            mq.delete();
            m_capturing = 0;
            m_draining  = 0;
            m_ovf       = 0;
            m_cnt       = 0;
            model_live  = 1;
        end else begin
            bit was_draining;
            bit do_pop;
            bit was_full;
            was_draining = m_draining;
            do_pop   = (mq.size() > 0) && DAC_READY;
            was_full = (mq.size() == 16);
            if (do_pop) popped.push_back(mq.pop_front());
            if (m_capturing) begin
                if (!was_full || do_pop) begin
                    mq.push_back(DATA_IN);
                    if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                end else begin
                    m_ovf = 1;
                end
                if (SIGN_STOP_CALC) begin
                    m_capturing = 0;
                    m_draining  = 1;
                end
            end else if (!m_draining && SIGN_START_CALC) begin
                m_capturing = 1;
                m_cnt = 0;
                m_ovf = 0;
            end
            if (was_draining && mq.size() == 0) m_draining = 0;
        end
    end

    always @(negedge CLK) begin
        if (model_live && !RESET) begin
            bit idle;
            idle = !m_capturing && !m_draining;
            check("ready", 32'(OUT_REG_READY), 32'(idle));
            check("busy", 32'(BUSY), 32'(!idle));
            check("valid", 32'(DAC_VALID), 32'(mq.size() != 0));
            check("data", 32'(DAC_DATA), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
            check("overflow", 32'(OVERFLOW), 32'(m_ovf));
            check("count", SAMPLE_COUNT, m_cnt[31:0]);
        end
    end

    // ready_mode: 0 = always ready, 1 = not ready until after STOP, 2 = toggling during capture.
    task automatic burst(input int n, input logic [11:0] base, input int ready_mode,
                         input bit start_in_drain);
        @(posedge CLK); #1;
        SIGN_START_CALC = 1'b1;
        DAC_READY = (ready_mode == 0);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            SIGN_START_CALC = 1'b0;
            DATA_IN = base + 12'(i);
            SIGN_STOP_CALC = (i == n - 1);
            DAC_READY = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : 1'(i % 2);
        end
        @(posedge CLK); #1;
        SIGN_STOP_CALC = 1'b0;
        DATA_IN = '0;
        DAC_READY = 1'b1;
        SIGN_START_CALC = start_in_drain;
        @(posedge CLK); #1;
        SIGN_START_CALC = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!OUT_REG_READY && k < 200) begin
            @(posedge CLK); #1;
            k++;
        end
        check(name, 32'(OUT_REG_READY), 32'd1);
    endtask

    initial begin
        int mark;
        bit seq_ok;

        // Reset, then idle
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("rst_ready", 32'(OUT_REG_READY), 32'd1);
        check("rst_valid", 32'(DAC_VALID), 32'd0);
        check("rst_data", 32'(DAC_DATA), 32'd0);
        check("rst_count", SAMPLE_COUNT, 32'd0);
        check("rst_ovf", 32'(OVERFLOW), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);

        // 8 samples, DAC always ready
        mark = popped.size();
        burst(8, 12'h001, 0, 1'b0);
        wait_idle("b8_idle");
        check("b8_count", SAMPLE_COUNT, 32'd8);
        check("b8_ovf", 32'(OVERFLOW), 32'd0);
        check("b8_npop", 32'(popped.size() - mark), 32'd8);
        seq_ok = 1;
        for (int i = 0; i < 8; i++) if (popped[mark + i] != 12'(i + 1)) seq_ok = 0;
        check("b8_order", 32'(seq_ok), 32'd1);

        // 20 samples into a stalled DAC: 4 dropped
        mark = popped.size();
        burst(20, 12'h001, 1, 1'b0);
        wait_idle("b20_idle");
        check("b20_count", SAMPLE_COUNT, 32'd16);
        check("b20_ovf", 32'(OVERFLOW), 32'd1);
        check("b20_npop", 32'(popped.size() - mark), 32'd16);
        seq_ok = 1;
        for (int i = 0; i < 16; i++) if (popped[mark + i] != 12'(i + 1)) seq_ok = 0;
        check("b20_order", 32'(seq_ok), 32'd1);

        // 40 samples, DAC ready toggling: full FIFO, drops on edges 32,34,36,38
        mark = popped.size();
        burst(40, 12'h100, 2, 1'b0);
        wait_idle("b40_idle");
        check("b40_count", SAMPLE_COUNT, 32'd36);
        check("b40_ovf", 32'(OVERFLOW), 32'd1);
        check("b40_npop", 32'(popped.size() - mark), 32'd36);
        check("b40_first", 32'(popped[mark]), 32'h100);
        check("b40_last", 32'(popped[popped.size() - 1]), 32'h127);

        // One-sample burst with a START during DRAIN
        mark = popped.size();
        burst(1, 12'hABC, 0, 1'b1);
        @(negedge CLK);
        check("b1_idle", 32'(OUT_REG_READY), 32'd1);
        check("b1_count", SAMPLE_COUNT, 32'd1);
        check("b1_ovf", 32'(OVERFLOW), 32'd0);
        check("b1_npop", 32'(popped.size() - mark), 32'd1);
        check("b1_val", 32'(popped[mark]), 32'hABC);

        // RESET mid-capture with 5 samples buffered
        @(posedge CLK); #1;
        SIGN_START_CALC = 1'b1;
        DAC_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            SIGN_START_CALC = 1'b0;
            DATA_IN = 12'h050 + 12'(i);
        end
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        check("mr_valid", 32'(DAC_VALID), 32'd0);
        check("mr_ready", 32'(OUT_REG_READY), 32'd1);
        check("mr_count", SAMPLE_COUNT, 32'd0);
        check("mr_busy", 32'(BUSY), 32'd0);
        mark = popped.size();
        burst(3, 12'h7F0, 0, 1'b0);
        wait_idle("mr_idle");
        check("mr_npop", 32'(popped.size() - mark), 32'd3);
        check("mr_first", 32'(popped[mark]), 32'h7F0);
        check("mr_cnt3", SAMPLE_COUNT, 32'd3);

        repeat (3) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
